serial_adder_ctrl: RTL and testbench

SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

---
 rtl/serial_adder_ctrl.sv | 105 ++++++++++
 tb/tb_serial_adder_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder slice stepped LSB first over WIDTH cycles.
// Result and carry-out are registered and held until the next completion.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] psum;
  logic [CW-1:0]    cnt;
  logic             carry;

  logic             h1_s;
  logic             h1_c;
  logic             h2_s;
  logic             h2_c;
  logic             c_nx;
  logic [WIDTH-1:0] top_bit;
  logic [WIDTH-1:0] psum_nx;

  // Two half adders plus a carry OR form the full-adder slice.
  always_comb begin
    h1_s = sa[0] ^ sb[0];
    h1_c = sa[0] & sb[0];
    h2_s = h1_s ^ carry;
    h2_c = h1_s & carry;
    c_nx = h1_c | h2_c;
    top_bit = '0;
    top_bit[WIDTH-1] = h2_s;
    psum_nx = (psum >> 1) | top_bit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sa    <= '0;
      sb    <= '0;
      psum  <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sa    <= a;
            sb    <= b;
            psum  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          psum  <= psum_nx;
          sa    <= sa >> 1;
          sb    <= sb >> 1;
          carry <= c_nx;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST) begin
            sum   <= psum_nx;
            cout  <= c_nx;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl (WIDTH=8): driver pushes a+b,
// monitor pops on every done pulse and checks timing and held outputs.
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [W:0] q[$];
  logic [W:0] last_res = '0;
  bit         held = 1'b0;
  bit         have_prev = 1'b0;
  int         last_done = 0;
  int         busy_run = 0;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .a(a),
    .b(b),
    .busy(busy),
    .done(done),
    .sum(sum),
    .cout(cout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // Monitor: compares against the scoreboard, never drives.
  always @(negedge clk) begin
    if (!rst) begin
      if (done) begin
        if (q.size() == 0) begin
          check("unexpected_done", 32'(done), 32'd0);
        end else begin
          last_res = q.pop_front();
          check("result", 32'({cout, sum}), 32'(last_res));
        end
        check("busy_len", 32'(busy_run), 32'(W));
        check("busy_in_done", 32'(busy), 32'd0);
        if (held && have_prev)
          check("done_period", 32'(cyc - last_done), 32'(W + 2));
        have_prev = held;
        last_done = cyc;
        busy_run = 0;
      end else begin
        check("hold", 32'({cout, sum}), 32'(last_res));
        if (busy) busy_run++;
        else busy_run = 0;
      end
    end
  end

  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    a = x;
    b = y;
    start = 1'b1;
    q.push_back({1'b0, x} + {1'b0, y});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      check("drain_timeout", 32'(q.size()), 32'd0);
      q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    // Reset held with no start: outputs stay cleared.
    repeat (4) begin
      @(negedge clk);
      check("rst_out", 32'({busy, done, cout, sum}), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;

    issue(8'h0F, 8'h01);
    drain();
    issue(8'hFF, 8'h01);
    drain();
    issue(8'hA5, 8'h5A);
    drain();

    // start and new operands during RUN must be ignored.
    issue(8'h03, 8'h04);
    @(negedge clk);
    start = 1'b1;
    a = 8'hFF;
    b = 8'hFF;
    repeat (2) @(negedge clk);
    start = 1'b0;
    drain();

    // Asynchronous reset mid-run discards the operation.
    issue(8'h80, 8'h80);
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b1;
    q.delete();
    last_res = '0;
    #1;
    check("async_rst", 32'({busy, done, cout, sum}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    issue(8'h80, 8'h80);
    drain();

    // Boundary sums.
    issue(8'h00, 8'h00);
    drain();
    issue(8'hFF, 8'hFF);
    drain();

    // Start held high: one accept every W+2 edges.
    held = 1'b1;
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 100; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      q.push_back({1'b0, a} + {1'b0, b});
      repeat (W + 2) @(negedge clk);
    end
    start = 1'b0;
    drain();
    held = 1'b0;

    check("queue_empty", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
